ipd_stage: RTL



---
 rtl/ipd_stage_pkg.sv | 27 ++
 rtl/ipd_predecoder.sv | 38 +++
 rtl/ipd_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/ipd_stage_pkg.sv
// Shared definitions for the IPD (instruction pre-decode) stage: bus widths,
// LA32R branch/jump opcodes and offset sign-extension helpers.
package ipd_stage_pkg;

  localparam int IF_TO_IPD_BUS_WD = 96;
  localparam int IPD_TO_ID_BUS_WD = 131;

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [5:0] OP_BLT  = 6'h18;
  localparam logic [5:0] OP_BGE  = 6'h19;
  localparam logic [5:0] OP_BLTU = 6'h1A;
  localparam logic [5:0] OP_BGEU = 6'h1B;

  // Word offset -> sign-extended byte offset.
  function automatic logic [31:0] sext_offs16(input logic [15:0] offs);
    return {{14{offs[15]}}, offs, 2'b00};
  endfunction

  function automatic logic [31:0] sext_offs26(input logic [25:0] offs);
    return {{4{offs[25]}}, offs, 2'b00};
  endfunction

endpackage

// File: rtl/ipd_predecoder.sv
// Combinational LA32R branch/jump pre-decoder. Only pc-relative targets are
// computed here; jirl targets depend on a register and are resolved in ID.
module ipd_predecoder
  import ipd_stage_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        is_br,
  output logic        is_bl,
  output logic        is_jirl,
  output logic [31:0] br_target
);

  logic [5:0] op;
  assign op = inst[31:26];

  // Classify the opcode and form the pc-relative target (wraps mod 2^32).
  always_comb begin
    is_br     = 1'b0;
    is_bl     = 1'b0;
    is_jirl   = 1'b0;
    br_target = '0;
    case (op)
      OP_B, OP_BL: begin
        is_br     = 1'b1;
        is_bl     = (op == OP_BL);
        br_target = pc + sext_offs26({inst[9:0], inst[25:10]});
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        is_br     = 1'b1;
        br_target = pc + sext_offs16(inst[25:10]);
      end
      OP_JIRL: is_jirl = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ipd_stage.sv
// IPD pipeline stage: takes {pred_pc, pc} from IF, pairs it with the inst RAM
// data that arrives one cycle later, holds that data in a skid register while
// ID stalls, and forwards the entry plus branch pre-decode to ID.
module ipd_stage
  import ipd_stage_pkg::*;
#(
  parameter int PREDECODE_EN = 1,
  parameter int INST_W       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        IF_to_IPD_valid,
  input  logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
  output logic                        IPD_allow_in,
  input  logic [INST_W-1:0]           inst_ram_r_data,
  input  logic                        flush,
  input  logic                        ID_allow_in,
  output logic                        IPD_to_ID_valid,
  output logic [IPD_TO_ID_BUS_WD-1:0] IPD_to_ID_bus
);

  logic              ipd_valid;
  logic              fresh;
  logic              buf_valid;
  logic [INST_W-1:0] pc_r;
  logic [INST_W-1:0] pred_pc_r;
  logic [INST_W-1:0] inst_buf;
  logic [INST_W-1:0] inst;
  logic              accept;
  logic              out_xfer;
  logic              is_br;
  logic              is_bl;
  logic              is_jirl;
  logic [31:0]       br_target;

  // Low 32 bits of the IF bus carry nothing for this stage; buf_valid is
  // kept as status only, since fresh alone selects the instruction source.
  logic unused_sig;
  assign unused_sig = ^{IF_to_IPD_bus[31:0], buf_valid};

  // Stage has a single slot and always completes in one cycle (ready_go=1).
  assign IPD_allow_in    = ~ipd_valid | ID_allow_in;
  assign IPD_to_ID_valid = ipd_valid & ~flush;
  assign accept          = IF_to_IPD_valid & IPD_allow_in & ~flush;
  assign out_xfer        = ipd_valid & ID_allow_in;

  // RAM data is only valid the cycle after acceptance; afterwards use the copy.
  assign inst = fresh ? inst_ram_r_data : inst_buf;

  // Slot state: flush beats accept, accept replaces a leaving entry without a
  // bubble, and a stalled fresh instruction is parked in inst_buf.
  always_ff @(posedge clk) begin
    if (reset) begin
      ipd_valid <= 1'b0;
      fresh     <= 1'b0;
      buf_valid <= 1'b0;
      pc_r      <= '0;
      pred_pc_r <= '0;
      inst_buf  <= '0;
    end else if (flush) begin
      ipd_valid <= 1'b0;
      fresh     <= 1'b0;
      buf_valid <= 1'b0;
    end else if (accept) begin
      ipd_valid <= 1'b1;
      fresh     <= 1'b1;
      buf_valid <= 1'b0;
      pc_r      <= IF_to_IPD_bus[63:32];
      pred_pc_r <= IF_to_IPD_bus[95:64];
    end else if (out_xfer) begin
      ipd_valid <= 1'b0;
      fresh     <= 1'b0;
      buf_valid <= 1'b0;
    end else if (fresh && !ID_allow_in) begin
      inst_buf  <= inst_ram_r_data;
      buf_valid <= 1'b1;
      fresh     <= 1'b0;
    end
  end

  if (PREDECODE_EN != 0) begin : g_predecode
    ipd_predecoder u_predecoder (
      .inst      (inst),
      .pc        (pc_r),
      .is_br     (is_br),
      .is_bl     (is_bl),
      .is_jirl   (is_jirl),
      .br_target (br_target)
    );
  end else begin : g_no_predecode
    assign is_br     = 1'b0;
    assign is_bl     = 1'b0;
    assign is_jirl   = 1'b0;
    assign br_target = '0;
  end

  assign IPD_to_ID_bus = {is_jirl, is_bl, is_br, br_target, inst, pc_r, pred_pc_r};

endmodule
